tree_plru_victim: RTL and testbench
===================================

TREE_PLRU_VICTIM -- requirements
Module: tree_plru_victim

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways; power of two, >= 2.
REQ-002 SHALL have parameter DEPTH, default $clog2(WAYS), number of tree levels.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port touch_en  input  1  access-hit update strobe.
REQ-006 SHALL have port touch_way  input  DEPTH  way marked most-recently-used.
REQ-007 SHALL have port req_valid  input  1  victim request.
REQ-008 SHALL have port req_ready  output  1  request accepted when both high.
REQ-009 SHALL have port req_lock_mask  input  WAYS  1 = way not selectable.
REQ-010 SHALL have port req_vld_mask  input  WAYS  1 = way holds valid line.
REQ-011 SHALL have port resp_valid  output  1  victim result available.
REQ-012 SHALL have port resp_ready  input  1  result consumed when both high.
REQ-013 SHALL have port resp_way  output  DEPTH  victim index.
REQ-014 SHALL have port resp_onehot  output  WAYS  victim one-hot; zero when resp_none.
REQ-015 SHALL have port resp_none  output  1  no selectable way.

Function
REQ-016 SHALL hold WAYS-1 tree bits, heap-indexed: root 0, children of n at 2n+1 and 2n+2.
REQ-017 SHALL interpret a node bit of 0 as victim-in-left-subtree and 1 as victim-in-right-subtree.
REQ-018 SHALL, on touch of way w, set every node on w's root-to-leaf path to 1 if w lies in its left subtree, else 0.
REQ-019 SHALL implement states IDLE, WALK, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL, on acceptance, register both masks and snapshot the tree; the walk uses only the snapshot.
REQ-021 SHALL, when all ways locked, go to RESP with resp_none=1, resp_way=0, resp_onehot=0.
REQ-022 SHALL otherwise, when any unlocked way is invalid, go to RESP with the lowest-index such way (fast path).
REQ-023 SHALL otherwise enter WALK, resolving one tree level per cycle from root for exactly DEPTH cycles, then enter RESP.
REQ-024 SHALL at each WALK level follow the node bit, but take the sibling subtree when the indicated subtree is fully locked.
REQ-025 SHALL assert resp_valid 1 cycle after acceptance (fast/none path) or DEPTH+1 cycles after acceptance (walk path).
REQ-026 SHALL hold resp_valid, resp_way, resp_onehot, resp_none stable while resp_valid=1 and resp_ready=0.
REQ-027 SHALL on resp handshake return to IDLE and, if resp_none=0, apply a touch of resp_way to the live tree.
REQ-028 SHALL accept touch_en in every state; touch updates the live tree, never the snapshot.
REQ-029 SHALL, when touch_en coincides with the REQ-027 commit, apply the commit first and the touch last (touch wins conflicting nodes).
REQ-030 SHALL not accept a new request in the handshake cycle; earliest new acceptance is the following cycle.

Reset
REQ-031 SHALL on rst=1 clear all tree bits to 0, enter IDLE, drive resp_valid=0, resp_way=0, resp_onehot=0, resp_none=0.
REQ-032 SHALL on rst mid-WALK or mid-RESP abandon the request with no tree update; req_ready=1 the next cycle.
REQ-033 SHALL give rst priority over touch_en and handshakes in the same cycle.

Verification (WAYS=4)
REQ-034 SHALL cover: reset, vld_mask=1111, lock=0000, request -> resp_way=0, onehot=0001, resp_valid 3 cycles after acceptance.
REQ-035 SHALL cover: reset, touch 0 then touch 1, request (all valid, unlocked) -> resp_way=2; then commit, new request -> resp_way=0 (touch 2 sets n0=0,n2=1; n1=0 still points left).
REQ-036 SHALL cover: reset, lock=0011, all valid -> resp_way=2 via walk; lock=1111 -> resp_none=1, onehot=0000, tree unchanged.
REQ-037 SHALL cover: vld_mask=1011, lock=0100 -> resp_way=3 fast path? no: way2 locked, no other invalid -> walk result; vld_mask=1011, lock=0000 -> resp_way=2, resp_valid 1 cycle after acceptance.
REQ-038 SHALL cover: resp_ready held low 5 cycles -> outputs stable; touch_en of way 0 coincident with commit of way 2 -> n0=1, n1=1, n2=1.
REQ-039 SHALL cover: rst asserted in second WALK cycle -> resp_valid stays 0, tree bits all 0, req_ready=1 next cycle.

Source files
------------

// File: rtl/tree_plru_victim_if.sv
// Victim-selection bus: access-hit touches, victim requests and victim responses.
// master drives requests/touches and consumes responses; slave is the PLRU engine.
interface tree_plru_victim_if #(
  parameter int WAYS  = 4,
  parameter int DEPTH = $clog2(WAYS)
);
  logic             touch_en;
  logic [DEPTH-1:0] touch_way;
  logic             req_valid;
  logic             req_ready;
  logic [WAYS-1:0]  req_lock_mask;
  logic [WAYS-1:0]  req_vld_mask;
  logic             resp_valid;
  logic             resp_ready;
  logic [DEPTH-1:0] resp_way;
  logic [WAYS-1:0]  resp_onehot;
  logic             resp_none;

  modport master (
    output touch_en, touch_way, req_valid, req_lock_mask, req_vld_mask, resp_ready,
    input  req_ready, resp_valid, resp_way, resp_onehot, resp_none
  );

  modport slave (
    input  touch_en, touch_way, req_valid, req_lock_mask, req_vld_mask, resp_ready,
    output req_ready, resp_valid, resp_way, resp_onehot, resp_none
  );
endinterface

// File: rtl/tree_plru_victim.sv
// Tree pseudo-LRU victim selector: heap-ordered tree bits, lock-aware walk over a
// snapshot of the tree, fast path for invalid ways, commit of the victim on handshake.
module tree_plru_victim #(
  parameter int WAYS  = 4,
  parameter int DEPTH = $clog2(WAYS)
) (
  input logic                clk,
  input logic                rst,
  tree_plru_victim_if.slave  bus
);
  localparam int NODES = WAYS - 1;
  localparam int NW    = $clog2(2 * WAYS);

  typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;

  state_t           state_q;
  logic [NODES-1:0] tree_q;
  logic [NODES-1:0] tree_d;
  logic [NODES-1:0] snap_q;
  logic [WAYS-1:0]  lock_q;
  logic [WAYS-1:0]  vld_q;
  logic [NW-1:0]    node_q;
  logic [DEPTH-1:0] prefix_q;
  logic [DEPTH-1:0] lvl_q;
  logic             resp_valid_q;
  logic [DEPTH-1:0] resp_way_q;
  logic [WAYS-1:0]  resp_onehot_q;
  logic             resp_none_q;

  logic             commit;
  logic [WAYS-1:0]  fast_cand;
  logic [DEPTH-1:0] fast_way;
  logic [2*WAYS-2:0] sub_lock;
  logic [2*WAYS-2:0] snap_ext;
  logic [NW-1:0]    left_n;
  logic [NW-1:0]    right_n;
  logic [NW-1:0]    next_node;
  logic             walk_dir;
  logic [DEPTH-1:0] next_prefix;

  assign commit    = (state_q == RESP) && bus.resp_ready && !resp_none_q;
  assign fast_cand = ~bus.req_lock_mask & ~bus.req_vld_mask;
  assign snap_ext  = {{WAYS{1'b0}}, snap_q};

  // Per heap node (internal and leaf): is every way below it locked in the captured mask?
  genvar gi;
  generate
    for (gi = 0; gi < 2 * WAYS - 1; gi++) begin : g_sub
      localparam int L = $clog2(gi + 2) - 1;
      localparam int O = gi + 1 - (1 << L);
      localparam int S = WAYS >> L;
      assign sub_lock[gi] = &lock_q[O*S +: S];
    end

    // Live-tree update: the handshake commit goes first, a coincident touch overrides it.
    for (gi = 0; gi < NODES; gi++) begin : g_node
      localparam int L = $clog2(gi + 2) - 1;
      localparam int O = gi + 1 - (1 << L);
      logic commit_hit;
      logic touch_hit;
      logic bit_d;
      assign commit_hit = commit && ((resp_way_q >> (DEPTH - L)) == DEPTH'(O));
      assign touch_hit  = bus.touch_en && ((bus.touch_way >> (DEPTH - L)) == DEPTH'(O));
      always_comb begin
        bit_d = tree_q[gi];
        if (commit_hit) bit_d = ~resp_way_q[DEPTH-1-L];
        if (touch_hit)  bit_d = ~bus.touch_way[DEPTH-1-L];
      end
      assign tree_d[gi] = bit_d;
    end
  endgenerate

  always_comb begin
    fast_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (fast_cand[i]) fast_way = DEPTH'(i);
    end
  end

  // One level of the walk: follow the snapshot bit unless that whole subtree is locked.
  always_comb begin
    left_n   = (node_q << 1) + NW'(1);
    right_n  = left_n + NW'(1);
    walk_dir = snap_ext[node_q];
    if (!walk_dir && sub_lock[left_n]) begin
      walk_dir = 1'b1;
    end else if (walk_dir && sub_lock[right_n]) begin
      walk_dir = 1'b0;
    end
    next_node   = walk_dir ? right_n : left_n;
    next_prefix = (prefix_q << 1) | DEPTH'(walk_dir);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tree_q        <= '0;
      snap_q        <= '0;
      lock_q        <= '0;
      vld_q         <= '0;
      node_q        <= '0;
      prefix_q      <= '0;
      lvl_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_way_q    <= '0;
      resp_onehot_q <= '0;
      resp_none_q   <= 1'b0;
    end else begin
      tree_q <= tree_d;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            snap_q   <= tree_q;
            lock_q   <= bus.req_lock_mask;
            vld_q    <= bus.req_vld_mask;
            node_q   <= '0;
            prefix_q <= '0;
            lvl_q    <= '0;
            if (&bus.req_lock_mask) begin
              state_q       <= RESP;
              resp_valid_q  <= 1'b1;
              resp_way_q    <= '0;
              resp_onehot_q <= '0;
              resp_none_q   <= 1'b1;
            end else if (|fast_cand) begin
              state_q       <= RESP;
              resp_valid_q  <= 1'b1;
              resp_way_q    <= fast_way;
              resp_onehot_q <= WAYS'(1) << fast_way;
              resp_none_q   <= 1'b0;
            end else begin
              state_q <= WALK;
            end
          end
        end
        WALK: begin
          node_q   <= next_node;
          prefix_q <= next_prefix;
          lvl_q    <= lvl_q + 1'b1;
          if (lvl_q == DEPTH'(DEPTH - 1)) begin
            state_q       <= RESP;
            resp_valid_q  <= 1'b1;
            resp_way_q    <= next_prefix;
            resp_onehot_q <= WAYS'(1) << next_prefix;
            resp_none_q   <= 1'b0;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_way    = resp_way_q;
  assign bus.resp_onehot = resp_onehot_q;
  assign bus.resp_none   = resp_none_q;
endmodule

// File: tb/tb_tree_plru_victim.sv
// Directed bench for tree_plru_victim (WAYS=4): vector table plus hand-written
// sequences for stalled responses, commit/touch collisions and mid-request reset.
module tb_tree_plru_victim;
  localparam int WAYS  = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tree_plru_victim_if #(.WAYS(WAYS), .DEPTH(DEPTH)) bus ();
  tree_plru_victim #(.WAYS(WAYS), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // tree bits shown as {n2, n1, n0}
  typedef struct {
    logic       do_rst;
    logic       t0_en;
    logic [1:0] t0_way;
    logic       t1_en;
    logic [1:0] t1_way;
    logic [3:0] lock;
    logic [3:0] vld;
    logic [1:0] exp_way;
    logic [3:0] exp_oh;
    logic       exp_none;
    int         exp_lat;
    logic [2:0] exp_tree;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic touch(input logic [1:0] w);
    bus.touch_en  = 1'b1;
    bus.touch_way = w;
    tick();
    bus.touch_en  = 1'b0;
  endtask

  task automatic request(input string tag, input logic [3:0] lock, input logic [3:0] vld,
                         output int lat);
    bus.req_lock_mask = lock;
    bus.req_vld_mask  = vld;
    bus.req_valid     = 1'b1;
    check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic commit_resp();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  int lat;

  initial begin
    //            rst   t0         t1         lock     vld      way    oh       none lat tree
    vecs[0] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b1111, 2'd0, 4'b0001, 1'b0, 3, 3'b011};
    vecs[1] = '{1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 4'b0000, 4'b1111, 2'd2, 4'b0100, 1'b0, 3, 3'b100};
    vecs[2] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b1111, 2'd0, 4'b0001, 1'b0, 3, 3'b111};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0011, 4'b1111, 2'd2, 4'b0100, 1'b0, 3, 3'b100};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1111, 4'b1111, 2'd0, 4'b0000, 1'b1, 1, 3'b100};
    vecs[5] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0100, 4'b1011, 2'd0, 4'b0001, 1'b0, 3, 3'b011};
    vecs[6] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b1011, 2'd2, 4'b0100, 1'b0, 1, 3'b110};
    vecs[7] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0010, 4'b0101, 2'd3, 4'b1000, 1'b0, 1, 3'b010};
    vecs[8] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0010, 4'b1111, 2'd0, 4'b0001, 1'b0, 3, 3'b011};
    vecs[9] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0100, 4'b1111, 2'd3, 4'b1000, 1'b0, 3, 3'b010};

    bus.touch_en      = 1'b0;
    bus.touch_way     = '0;
    bus.req_valid     = 1'b0;
    bus.req_lock_mask = '0;
    bus.req_vld_mask  = '0;
    bus.resp_ready    = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    check("reset/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset/resp_way", 32'(bus.resp_way), 32'd0);
    check("reset/resp_onehot", 32'(bus.resp_onehot), 32'd0);
    check("reset/resp_none", 32'(bus.resp_none), 32'd0);
    check("reset/tree", 32'(dut.tree_q), 32'd0);
    rst = 1'b0;
    tick();
    check("reset/req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_rst) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      if (vecs[i].t0_en) touch(vecs[i].t0_way);
      if (vecs[i].t1_en) touch(vecs[i].t1_way);
      request($sformatf("v%0d", i), vecs[i].lock, vecs[i].vld, lat);
      check($sformatf("v%0d/latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d/resp_way", i), 32'(bus.resp_way), 32'(vecs[i].exp_way));
      check($sformatf("v%0d/resp_onehot", i), 32'(bus.resp_onehot), 32'(vecs[i].exp_oh));
      check($sformatf("v%0d/resp_none", i), 32'(bus.resp_none), 32'(vecs[i].exp_none));
      commit_resp();
      check($sformatf("v%0d/tree", i), 32'(dut.tree_q), 32'(vecs[i].exp_tree));
    end

    // Stalled response, then touch of way 0 coincident with commit of way 2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    touch(2'd1);
    request("stall", 4'b0000, 4'b1111, lat);
    check("stall/latency", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall%0d/resp_valid", k), 32'(bus.resp_valid), 32'd1);
      check($sformatf("stall%0d/resp_way", k), 32'(bus.resp_way), 32'd2);
      check($sformatf("stall%0d/resp_onehot", k), 32'(bus.resp_onehot), 32'b0100);
      check($sformatf("stall%0d/resp_none", k), 32'(bus.resp_none), 32'd0);
    end
    bus.resp_ready = 1'b1;
    bus.touch_en   = 1'b1;
    bus.touch_way  = 2'd0;
    check("collide/req_ready_in_handshake", 32'(bus.req_ready), 32'd0);
    tick();
    bus.resp_ready = 1'b0;
    bus.touch_en   = 1'b0;
    check("collide/tree", 32'(dut.tree_q), 32'b111);
    check("collide/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("collide/req_ready", 32'(bus.req_ready), 32'd1);

    // Touch during the walk updates the live tree, not the snapshot.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_lock_mask = 4'b0000;
    bus.req_vld_mask  = 4'b1111;
    bus.req_valid     = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    touch(2'd0);
    lat = 2;
    while (!bus.resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("snap/latency", 32'(lat), 32'd3);
    check("snap/resp_way", 32'(bus.resp_way), 32'd0);
    check("snap/live_tree", 32'(dut.tree_q), 32'b011);
    commit_resp();

    // Reset in the second walk cycle, with a touch in the same cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst           = 1'b1;
    bus.touch_en  = 1'b1;
    bus.touch_way = 2'd0;
    tick();
    rst          = 1'b0;
    bus.touch_en = 1'b0;
    check("walkrst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("walkrst/tree", 32'(dut.tree_q), 32'd0);
    check("walkrst/req_ready", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 4; k++) tick();
    check("walkrst/resp_valid_later", 32'(bus.resp_valid), 32'd0);

    // Reset while a response is being handshaken: no commit.
    request("resprst", 4'b0000, 4'b1110, lat);
    check("resprst/latency", 32'(lat), 32'd1);
    check("resprst/resp_way", 32'(bus.resp_way), 32'd0);
    rst            = 1'b1;
    bus.resp_ready = 1'b1;
    tick();
    rst            = 1'b0;
    bus.resp_ready = 1'b0;
    check("resprst/tree", 32'(dut.tree_q), 32'd0);
    check("resprst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("resprst/req_ready", 32'(bus.req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
